halt_ctrl: RTL and testbench

- Core-side producer of the simulation halt report.
- Watches the commit stream for `ebreak` (32'h00100073) and watchdog expiry, then stalls fetch and waits for the pipeline to drain.
- Presents one latched halt record (cause, exit code from a0, pc, counters) to the simulation harness over a valid/ready handshake.
- Sits between the core's commit stage and the sim top-level; the harness consumes the record and ends the run.

---
 rtl/sim_pkg.sv | 25 ++
 rtl/commit_watchdog.sv | 32 +++
 rtl/halt_ctrl.sv | 108 ++++++++++
 tb/tb_halt_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_pkg.sv
// Shared definitions for the simulation halt path: the ebreak encoding, halt causes
// and the halt record layout also consumed by the harness bridge.
package sim_pkg;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
  localparam int          REC_XLEN    = 64;

  typedef enum logic [1:0] {
    CAUSE_GOOD_TRAP = 2'd0,
    CAUSE_BAD_TRAP  = 2'd1,
    CAUSE_TIMEOUT   = 2'd2
  } halt_cause_e;

  // Fixed 64-bit fields so the harness sees one layout regardless of core XLEN.
  typedef struct packed {
    halt_cause_e         cause;
    logic [REC_XLEN-1:0] code;
    logic [REC_XLEN-1:0] pc;
  } halt_rec_t;

  function automatic halt_cause_e trap_cause(input logic [REC_XLEN-1:0] a0);
    return (a0 == '0) ? CAUSE_GOOD_TRAP : CAUSE_BAD_TRAP;
  endfunction

endpackage

// File: rtl/commit_watchdog.sv
// Idle-commit watchdog: counts enabled cycles since the last commit and flags expiry
// on the cycle the count sits at TIMEOUT-1 with no commit arriving.
module commit_watchdog #(
  parameter int TIMEOUT = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expire
);

  localparam int              WD_W  = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + WD_W'(1);
    end
  end

  // A commit in the same cycle clears rather than expires, so ebreak beats timeout.
  assign o_expire = i_enable && !i_clear && (r_cnt == LIMIT);

endmodule

// File: rtl/halt_ctrl.sv
// Halt controller: detects ebreak or watchdog expiry on the commit stream, stalls fetch,
// waits for the pipeline to drain and hands one latched halt record to the harness.
module halt_ctrl
  import sim_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 100000,
  parameter int CNT_W   = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             commit_valid,
  input  logic [31:0]      commit_inst,
  input  logic [XLEN-1:0]  commit_pc,
  input  logic [XLEN-1:0]  commit_a0,
  input  logic             pipe_empty,
  output logic             stall_fetch,
  output logic             halt_valid,
  input  logic             halt_ready,
  output logic [1:0]       halt_cause,
  output logic [XLEN-1:0]  halt_code,
  output logic [XLEN-1:0]  halt_pc,
  output logic             halt_done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_REPORT, ST_DONE} state_e;

  state_e           r_state;
  state_e           w_next;
  halt_rec_t        r_rec;
  logic [XLEN-1:0]  r_last_pc;
  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_instret;
  logic             r_stall;
  logic             w_run;
  logic             w_commit;
  logic             w_ebreak;
  logic             w_expire;

  assign w_run    = (r_state == ST_RUN);
  assign w_commit = w_run && commit_valid;
  assign w_ebreak = w_commit && (commit_inst == EBREAK_INST);

  commit_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock    (clock),
    .reset    (reset),
    .i_enable (w_run),
    .i_clear  (w_commit),
    .o_expire (w_expire)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_next;
  end

  // NOTE: next state gets its default first so no path through the case infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RUN:    if (w_ebreak || w_expire) w_next = ST_DRAIN;
      ST_DRAIN:  if (pipe_empty)           w_next = ST_REPORT;
      ST_REPORT: if (halt_ready)           w_next = ST_DONE;
      ST_DONE:                             w_next = ST_DONE;
      default:                             w_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall   <= 1'b0;
      r_rec     <= '0;
      r_last_pc <= '0;
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      r_stall <= (w_next != ST_RUN);
      if (r_state == ST_RUN || r_state == ST_DRAIN) begin
        r_cycle <= r_cycle + CNT_W'(1);
      end
      if (w_commit) begin
        r_instret <= r_instret + CNT_W'(1);
        r_last_pc <= commit_pc;
      end
      if (w_ebreak) begin
        r_rec <= '{cause: trap_cause(REC_XLEN'(commit_a0)),
                   code:  REC_XLEN'(commit_a0),
                   pc:    REC_XLEN'(commit_pc)};
      end else if (w_expire) begin
        r_rec <= '{cause: CAUSE_TIMEOUT,
                   code:  REC_XLEN'({XLEN{1'b1}}),
                   pc:    REC_XLEN'(r_last_pc)};
      end
    end
  end

  assign stall_fetch = r_stall;
  assign halt_valid  = (r_state == ST_REPORT);
  assign halt_done   = (r_state == ST_DONE);
  assign halt_cause  = r_rec.cause;
  assign halt_code   = r_rec.code[XLEN-1:0];
  assign halt_pc     = r_rec.pc[XLEN-1:0];
  assign cycle_cnt   = r_cycle;
  assign instret_cnt = r_instret;

endmodule

// File: tb/tb_halt_ctrl.sv
// Scoreboard bench for halt_ctrl: stimulus queues expected halt records, a negedge
// monitor pops and compares them on every handshake and checks record stability.
module tb_halt_ctrl;
  import sim_pkg::*;

  localparam int          XLEN  = 64;
  localparam int          CNT_W = 64;
  localparam int          TMO   = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    logic [1:0]  cause;
    logic [63:0] code;
    logic [63:0] pc;
    logic [63:0] instret;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             commit_valid = 1'b0;
  logic [31:0]      commit_inst = NOP;
  logic [XLEN-1:0]  commit_pc = '0;
  logic [XLEN-1:0]  commit_a0 = '0;
  logic             pipe_empty = 1'b1;
  logic             halt_ready = 1'b1;
  logic             stall_fetch;
  logic             halt_valid;
  logic [1:0]       halt_cause;
  logic [XLEN-1:0]  halt_code;
  logic [XLEN-1:0]  halt_pc;
  logic             halt_done;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  halt_ctrl #(.XLEN(XLEN), .TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .commit_valid (commit_valid),
    .commit_inst  (commit_inst),
    .commit_pc    (commit_pc),
    .commit_a0    (commit_a0),
    .pipe_empty   (pipe_empty),
    .stall_fetch  (stall_fetch),
    .halt_valid   (halt_valid),
    .halt_ready   (halt_ready),
    .halt_cause   (halt_cause),
    .halt_code    (halt_code),
    .halt_pc      (halt_pc),
    .halt_done    (halt_done),
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic commit(input logic [63:0] pc, input logic [31:0] inst, input logic [63:0] a0);
    commit_valid = 1'b1;
    commit_pc    = pc;
    commit_inst  = inst;
    commit_a0    = a0;
    step();
    commit_valid = 1'b0;
    commit_inst  = NOP;
  endtask

  task automatic push(input logic [1:0] cause, input logic [63:0] code,
                      input logic [63:0] pc, input logic [63:0] instret);
    exp_t e;
    e.cause   = cause;
    e.code    = code;
    e.pc      = pc;
    e.instret = instret;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"},   64'(halt_valid),  64'd0);
    check({tag, "_stall"},   64'(stall_fetch), 64'd0);
    check({tag, "_done"},    64'(halt_done),   64'd0);
    check({tag, "_cause"},   64'(halt_cause),  64'd0);
    check({tag, "_code"},    halt_code,        64'd0);
    check({tag, "_pc"},      halt_pc,          64'd0);
    check({tag, "_cycle"},   cycle_cnt,        64'd0);
    check({tag, "_instret"}, instret_cnt,      64'd0);
  endtask

  task automatic do_reset(input string tag);
    reset        = 1'b1;
    commit_valid = 1'b0;
    step();
    step();
    check_reset_state(tag);
    reset = 1'b0;
  endtask

  // Monitor: compare on every accepted transfer and require a stable record while stalled.
  logic        prev_hold = 1'b0;
  logic [1:0]  prev_cause;
  logic [63:0] prev_code;
  logic [63:0] prev_pc;

  always @(negedge clock) begin
    if (halt_valid && prev_hold) begin
      check("hold_cause", 64'(halt_cause), 64'(prev_cause));
      check("hold_code",  halt_code,       prev_code);
      check("hold_pc",    halt_pc,         prev_pc);
    end
    if (halt_valid && halt_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_record: got record pc %h expected none", halt_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("rec_cause",   64'(halt_cause), 64'(mon_e.cause));
        check("rec_code",    halt_code,       mon_e.code);
        check("rec_pc",      halt_pc,         mon_e.pc);
        check("rec_instret", instret_cnt,     mon_e.instret);
      end
    end
    prev_hold  = halt_valid && !halt_ready;
    prev_cause = halt_cause;
    prev_code  = halt_code;
    prev_pc    = halt_pc;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish within bound");
    $fatal(1);
  end

  initial begin
    // GOOD trap: 10 commits then ebreak with a0=0, no drain or backpressure.
    pipe_empty = 1'b1;
    halt_ready = 1'b1;
    do_reset("rst0");
    for (int i = 0; i < 10; i++) begin
      commit(64'h8000_0000 + 64'(4 * i), NOP, 64'(i + 7));
      check("good_run_stall", 64'(stall_fetch), 64'd0);
    end
    push(2'd0, 64'd0, 64'h8000_0028, 64'd11);
    commit(64'h8000_0028, EBREAK_INST, 64'd0);
    check("good_drain_stall", 64'(stall_fetch), 64'd1);
    check("good_drain_valid", 64'(halt_valid),  64'd0);
    step();
    check("good_report_valid", 64'(halt_valid), 64'd1);
    step();
    check("good_done",       64'(halt_done),  64'd1);
    check("good_done_valid", 64'(halt_valid), 64'd0);
    commit(64'h9000_0000, EBREAK_INST, 64'd1);
    commit(64'h9000_0004, NOP, 64'd2);
    check("good_frozen_instret", instret_cnt,      64'd11);
    check("good_frozen_cycle",   cycle_cnt,        64'd12);
    check("good_frozen_pc",      halt_pc,          64'h8000_0028);
    check("good_frozen_stall",   64'(stall_fetch), 64'd1);

    // BAD trap with 4-cycle drain, two ignored commits, and 3 cycles of backpressure.
    do_reset("rst1");
    halt_ready = 1'b0;
    commit(64'h8000_1000, NOP, 64'd1);
    commit(64'h8000_1004, NOP, 64'd2);
    push(2'd1, 64'd5, 64'h8000_1008, 64'd3);
    pipe_empty = 1'b0;
    commit(64'h8000_1008, EBREAK_INST, 64'd5);
    commit(64'h8000_100C, NOP, 64'h77);
    check("bad_drain_stall0", 64'(stall_fetch), 64'd1);
    commit(64'h8000_1010, EBREAK_INST, 64'd0);
    check("bad_drain_valid1", 64'(halt_valid), 64'd0);
    step();
    step();
    check("bad_drain_stall3",  64'(stall_fetch), 64'd1);
    check("bad_drain_valid3",  64'(halt_valid),  64'd0);
    check("bad_drain_instret", instret_cnt,      64'd3);
    check("bad_drain_code",    halt_code,        64'd5);
    pipe_empty = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      check("bad_report_valid", 64'(halt_valid),  64'd1);
      check("bad_report_stall", 64'(stall_fetch), 64'd1);
      step();
    end
    check("bad_report_valid4", 64'(halt_valid), 64'd1);
    halt_ready = 1'b1;
    step();
    check("bad_done", 64'(halt_done), 64'd1);

    // Timeout: one commit then silence; expiry after 16 idle cycles.
    do_reset("rst2");
    commit(64'h8000_0000, NOP, 64'd3);
    push(2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000, 64'd1);
    for (int i = 0; i < TMO - 1; i++) begin
      step();
      check("tmo_idle_stall", 64'(stall_fetch), 64'd0);
    end
    step();
    check("tmo_drain_stall", 64'(stall_fetch), 64'd1);
    check("tmo_drain_valid", 64'(halt_valid),  64'd0);
    step();
    check("tmo_report_valid", 64'(halt_valid), 64'd1);
    step();
    check("tmo_done",  64'(halt_done), 64'd1);
    check("tmo_cycle", cycle_cnt,      64'd18);

    // Ebreak exactly on the watchdog-expiry cycle: trap cause, never timeout.
    do_reset("rst3");
    commit(64'h8000_2000, NOP, 64'd0);
    for (int i = 0; i < TMO - 1; i++) step();
    check("sim_pre_stall", 64'(stall_fetch), 64'd0);
    push(2'd1, 64'd3, 64'h8000_2004, 64'd2);
    commit(64'h8000_2004, EBREAK_INST, 64'd3);
    check("sim_drain_stall", 64'(stall_fetch), 64'd1);
    step();
    step();
    check("sim_done", 64'(halt_done), 64'd1);

    // Reset while the record is presented and not yet accepted.
    do_reset("rst4");
    halt_ready = 1'b0;
    commit(64'h8000_3000, EBREAK_INST, 64'd0);
    step();
    check("mid_report_valid", 64'(halt_valid), 64'd1);
    reset = 1'b1;
    step();
    check_reset_state("mid_rst");
    reset      = 1'b0;
    halt_ready = 1'b1;
    push(2'd1, 64'd9, 64'h8000_3010, 64'd1);
    commit(64'h8000_3010, EBREAK_INST, 64'd9);
    step();
    check("post_rst_valid", 64'(halt_valid), 64'd1);
    step();
    check("post_rst_done", 64'(halt_done), 64'd1);

    step();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
